instruction_bank: RTL
=====================

INSTRUCTION_BANK -- requirements
Module: instruction_bank

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 19, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 128, number of instruction slots (power of two).
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, byte-address bus width.
REQ-004 SHALL have parameter SLOT_SHIFT, default 2, log2 of byte stride per slot (one instruction per 4 bytes).
REQ-005 SHALL have parameter LOAD_BYTES, default 3, bytes per instruction on the load port (8*LOAD_BYTES >= INSTR_WIDTH).
REQ-006 SHALL have port clk, input, 1, sole clock (rising edge).
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port rd_req, input, 1, read request.
REQ-009 SHALL have port rd_addr, input, ADDR_WIDTH, byte address of instruction.
REQ-010 SHALL have port rd_valid, output, 1, rd_data/rd_err valid this cycle.
REQ-011 SHALL have port rd_data, output, INSTR_WIDTH, fetched instruction.
REQ-012 SHALL have port rd_err, output, 1, misaligned, out-of-range or blocked read.
REQ-013 SHALL have port ld_start, input, 1, pulse starting a program load.
REQ-014 SHALL have port ld_base, input, ADDR_WIDTH, byte address of first loaded slot, sampled with ld_start.
REQ-015 SHALL have port ld_byte_valid, input, 1, ld_byte presented.
REQ-016 SHALL have port ld_byte, input, 8, load byte, most-significant byte first.
REQ-017 SHALL have port ld_byte_ready, output, 1, bank accepts ld_byte this cycle.
REQ-018 SHALL have port ld_stop, input, 1, pulse ending the load.
REQ-019 SHALL have port ld_busy, output, 1, load in progress.
REQ-020 SHALL have port ld_count, output, ADDR_WIDTH, instructions written in current/last load.
REQ-021 SHALL have port ld_overflow, output, 1, sticky: load ran past slot DEPTH-1.

Function
REQ-022 Slot index SHALL be rd_addr >> SLOT_SHIFT; address is misaligned if low SLOT_SHIFT bits nonzero, out of range if index >= DEPTH.
REQ-023 Read latency SHALL be exactly 1 cycle: rd_req at edge N -> rd_valid=1 for one cycle after edge N+1, back-to-back reads fully pipelined.
REQ-024 Misaligned, out-of-range, or ld_busy reads SHALL give rd_valid=1, rd_err=1, rd_data=0.
REQ-025 rd_data SHALL hold its last value while rd_valid=0.
REQ-026 Load FSM states SHALL be IDLE, COLLECT, WRITE.
REQ-027 IDLE: ld_start -> COLLECT, write pointer = ld_base>>SLOT_SHIFT, byte counter=0, ld_count=0, ld_overflow=0; ld_start ignored outside IDLE.
REQ-028 COLLECT: ld_byte_ready=1; each ld_byte_valid&&ld_byte_ready shifts byte into assembly register; on the LOAD_BYTES-th byte -> WRITE.
REQ-029 Assembled word SHALL be the low INSTR_WIDTH bits of the LOAD_BYTES bytes concatenated (first byte most significant); excess high bits discarded.
REQ-030 WRITE: ld_byte_ready=0; write word to pointer slot, pointer+1, ld_count+1, byte counter=0, -> COLLECT; one cycle.
REQ-031 If pointer equals DEPTH the write SHALL be suppressed, ld_overflow set, FSM -> IDLE.
REQ-032 ld_stop in COLLECT SHALL discard any partial word and -> IDLE; ld_stop in WRITE completes the write then -> IDLE.
REQ-033 ld_busy SHALL be 1 exactly in COLLECT and WRITE.
REQ-034 Misaligned ld_base SHALL be truncated to its slot (low bits ignored).

Reset
REQ-035 reset SHALL force FSM IDLE, rd_valid=0, rd_err=0, rd_data=0, ld_byte_ready=0, ld_busy=0, ld_count=0, ld_overflow=0, taking priority over all inputs.
REQ-036 reset SHALL NOT clear memory contents; slots written before reset mid-load are retained, partial word discarded.
REQ-037 Memory SHALL power up with all slots 0 (no built-in program).

Verification
REQ-038 Load base 0x000, bytes 02,01,10 / 00,83,0A, stop -> ld_count=2; read 0x000 -> 0x20110, 0x004 -> 0x0830A, each 1 cycle later, rd_err=0.
REQ-039 Read 0x006 -> rd_valid=1, rd_err=1, rd_data=0; read 0x200 (index 128) -> rd_err=1.
REQ-040 rd_req during load -> rd_err=1; after ld_stop, same address returns loaded value.
REQ-041 Load base 0x1FC (slot 127), 6 bytes -> slot 127 written, second word dropped, ld_overflow=1, ld_count=1, ld_busy=0.
REQ-042 Reset asserted after 4 bytes of a load -> ld_busy=0 next cycle; first word present in memory, second slot unchanged.
REQ-043 ld_byte_valid held high continuously -> ld_byte_ready low every 4th cycle; no byte lost or duplicated.

Source files
------------

// File: rtl/instruction_bank.sv
// Instruction bank: byte-addressed instruction memory with a registered
// one-cycle read port and a byte-serial program load port.
module instruction_bank #(
    parameter int INSTR_WIDTH = 19,
    parameter int DEPTH       = 128,
    parameter int ADDR_WIDTH  = 10,
    parameter int SLOT_SHIFT  = 2,
    parameter int LOAD_BYTES  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_req,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_valid,
    output logic [INSTR_WIDTH-1:0] rd_data,
    output logic                   rd_err,
    input  logic                   ld_start,
    input  logic [ADDR_WIDTH-1:0]  ld_base,
    input  logic                   ld_byte_valid,
    input  logic [7:0]             ld_byte,
    output logic                   ld_byte_ready,
    input  logic                   ld_stop,
    output logic                   ld_busy,
    output logic [ADDR_WIDTH-1:0]  ld_count,
    output logic                   ld_overflow
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BCNT_W = $clog2(LOAD_BYTES + 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BCNT_W-1:0]     LAST_BYTE = BCNT_W'(LOAD_BYTES - 1);
    localparam logic [BCNT_W-1:0]     BCNT_ONE  = BCNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic [INSTR_WIDTH-1:0]  asm_q, asm_d;
    logic                    ovf_q, ovf_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_err_q, rd_err_d;
    logic [INSTR_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                    mem_we;
    logic                    ptr_full;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic                    rd_bad;

    // Memory has no reset so a program survives a reset; it powers up cleared.
    logic [INSTR_WIDTH-1:0]  mem_q [DEPTH] = '{default: '0};

    assign ptr_full = ({1'b0, ptr_q} >= DEPTH_X);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d = COLLECT;
                    ptr_d   = ld_base >> SLOT_SHIFT;
                    count_d = '0;
                    bcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            COLLECT: begin
                if (ld_stop) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                end else if (ld_byte_valid) begin
                    // Shifting left drops bits above INSTR_WIDTH as they arrive.
                    asm_d = {asm_q[INSTR_WIDTH-9:0], ld_byte};
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d  = '0;
                        state_d = WRITE;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_ONE;
                    end
                end
            end
            WRITE: begin
                if (ptr_full) begin
                    ovf_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    mem_we  = !reset;
                    ptr_d   = ptr_q + ONE;
                    count_d = count_q + ONE;
                    state_d = ld_stop ? IDLE : COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads are refused while a load owns the memory.
    always_comb begin
        rd_idx     = rd_addr >> SLOT_SHIFT;
        rd_bad     = (|rd_addr[SLOT_SHIFT-1:0]) || ({1'b0, rd_idx} >= DEPTH_X)
                     || (state_q != IDLE);
        rd_valid_d = rd_req;
        rd_err_d   = rd_req && rd_bad;
        rd_data_d  = rd_data_q;
        if (rd_req) begin
            rd_data_d = rd_bad ? '0 : mem_q[rd_idx[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            bcnt_q     <= '0;
            asm_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q[IDX_W-1:0]] <= asm_q;
        end
    end

    assign rd_valid      = rd_valid_q;
    assign rd_err        = rd_err_q;
    assign rd_data       = rd_data_q;
    assign ld_byte_ready = (state_q == COLLECT);
    assign ld_busy       = (state_q != IDLE);
    assign ld_count      = count_q;
    assign ld_overflow   = ovf_q;
endmodule
